// File: rtl/coarse_coeff_buffer.sv
// -----------------------------------------------------------------------------
// coarse_coeff_buffer
//
// Holds the coarse (approximation) coefficients produced by one wavelet
// decomposition level and replays them into the lifting datapath as the input
// of the next level. The buffer fills, replays, and refills until the final
// approximation is reached.
//
// Storage is a circular FIFO of DEPTH entries, each DATA_W bits wide. A small
// FSM (FILL -> REPLAY -> FILL ... -> DONE) controls it. Writes that arrive
// during REPLAY are appended behind the entries being replayed. They are not
// part of the current replay; they form the input of the following level.
//
// Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   start               one-cycle pulse: flush buffer, level:=0, enter FILL
//   coarse_coeff_wr_en  write strobe from the lifting controller
//   coarse_in           coarse coefficient to store
//   level_done          one-cycle pulse: current level's input fully consumed
//   replay_ready        lifting datapath accepts a replayed sample
//   internal_valid      replayed sample valid
//   internal_data       replayed coarse coefficient (mem[rd_ptr])
//   level               current decomposition level, 0-based
//   occupancy           number of stored entries
//   all_done            final approximation reached (high while in DONE)
//   overflow            sticky: a write was dropped because the buffer was full
// -----------------------------------------------------------------------------
module coarse_coeff_buffer #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 8,
  parameter int NUM_LEVELS = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     coarse_coeff_wr_en,
  input  logic [DATA_W-1:0]        coarse_in,
  input  logic                     level_done,
  input  logic                     replay_ready,
  output logic                     internal_valid,
  output logic [DATA_W-1:0]        internal_data,
  output logic [1:0]               level,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     all_done,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    REPLAY = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Registered state
  state_t                  state_r;
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        occ_r;
  logic [CNT_W-1:0]        rem_r;
  logic [1:0]              level_r;
  logic                    valid_r;
  logic                    all_done_r;
  logic                    overflow_r;
  logic [DATA_W-1:0]       mem_r [DEPTH];

  // Combinational helpers
  logic                    pop_s;
  logic                    full_s;
  logic                    wr_ok_s;
  logic                    drop_s;
  logic                    advance_s;
  logic [CNT_W-1:0]        occ_nxt_s;

  // Handshake, write-acceptance and next-occupancy decode
  always_comb begin
    pop_s     = 1'b0;
    full_s    = 1'b0;
    wr_ok_s   = 1'b0;
    drop_s    = 1'b0;
    advance_s = 1'b0;
    occ_nxt_s = occ_r;

    pop_s  = valid_r && replay_ready;
    full_s = (occ_r == CNT_W'(DEPTH));

    // A full buffer can still accept a write when the same edge frees a slot.
    if (coarse_coeff_wr_en && (state_r != DONE)) begin
      if (!full_s || pop_s) begin
        wr_ok_s = 1'b1;
        drop_s  = 1'b0;
      end else begin
        wr_ok_s = 1'b0;
        drop_s  = 1'b1;
      end
    end else begin
      wr_ok_s = 1'b0;
      drop_s  = 1'b0;
    end

    if (wr_ok_s && !pop_s) begin
      occ_nxt_s = occ_r + CNT_W'(1);
    end else if (!wr_ok_s && pop_s) begin
      occ_nxt_s = occ_r - CNT_W'(1);
    end else begin
      occ_nxt_s = occ_r;
    end

    // Another level is worthwhile only with at least two samples to split,
    // counting a write that lands on the same edge as level_done.
    if (level_done && (occ_nxt_s >= CNT_W'(2)) &&
        (level_r < 2'(NUM_LEVELS - 1))) begin
      advance_s = 1'b1;
    end else begin
      advance_s = 1'b0;
    end
  end

  // Coefficient storage; contents need no reset
  always_ff @(posedge clk) begin
    if (rst_n && !start && wr_ok_s) begin
      mem_r[wr_ptr_r] <= coarse_in;
    end
  end

  // Control FSM, pointers, counters and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= FILL;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      occ_r      <= '0;
      rem_r      <= '0;
      level_r    <= 2'd0;
      valid_r    <= 1'b0;
      all_done_r <= 1'b0;
      overflow_r <= 1'b0;
    end else if (start) begin
      state_r    <= FILL;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      occ_r      <= '0;
      rem_r      <= '0;
      level_r    <= 2'd0;
      valid_r    <= 1'b0;
      all_done_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      // Pointers wrap DEPTH-1 -> 0 naturally because DEPTH is a power of 2.
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      occ_r <= occ_nxt_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end

      case (state_r)
        FILL: begin
          if (level_done) begin
            if (advance_s) begin
              state_r <= REPLAY;
              rem_r   <= occ_nxt_s;
              valid_r <= 1'b1;
            end else begin
              state_r    <= DONE;
              all_done_r <= 1'b1;
              valid_r    <= 1'b0;
            end
          end
        end

        REPLAY: begin
          // Pops only happen while valid, which implies rem_r != 0, so the
          // decrement cannot underflow. Appended writes never touch rem_r.
          if (pop_s) begin
            rem_r <= rem_r - CNT_W'(1);
            if (rem_r == CNT_W'(1)) begin
              state_r <= FILL;
              level_r <= level_r + 2'd1;
              valid_r <= 1'b0;
            end
          end
        end

        DONE: begin
          all_done_r <= 1'b1;
          valid_r    <= 1'b0;
        end

        default: begin
          state_r    <= FILL;
          valid_r    <= 1'b0;
          all_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign internal_valid = valid_r;
  assign internal_data  = mem_r[rd_ptr_r];
  assign level          = level_r;
  assign occupancy      = occ_r;
  assign all_done       = all_done_r;
  assign overflow       = overflow_r;

endmodule

// File: tb/tb_coarse_coeff_buffer.sv
// -----------------------------------------------------------------------------
// tb_coarse_coeff_buffer
//
// Directed bench for coarse_coeff_buffer. Inputs are driven and outputs are
// checked on the falling clock edge, midway between rising edges. Expected
// values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_coarse_coeff_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              coarse_coeff_wr_en;
  logic [DATA_W-1:0] coarse_in;
  logic              level_done;
  logic              replay_ready;
  logic              internal_valid;
  logic [DATA_W-1:0] internal_data;
  logic [1:0]        level;
  logic [3:0]        occupancy;
  logic              all_done;
  logic              overflow;

  int n_vec;
  int n_err;

  coarse_coeff_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_LEVELS(3)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .coarse_coeff_wr_en (coarse_coeff_wr_en),
    .coarse_in          (coarse_in),
    .level_done         (level_done),
    .replay_ready       (replay_ready),
    .internal_valid     (internal_valid),
    .internal_data      (internal_data),
    .level              (level),
    .occupancy          (occupancy),
    .all_done           (all_done),
    .overflow           (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [DATA_W-1:0] v);
    coarse_coeff_wr_en = 1'b1;
    coarse_in          = v;
    step();
    coarse_coeff_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_level_done();
    level_done = 1'b1;
    step();
    level_done = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    coarse_coeff_wr_en = 1'b0;
    coarse_in = '0;
    level_done = 1'b0;
    replay_ready = 1'b0;
    step();
    step();

    // Reset state
    check_val("rst_valid", 32'(internal_valid), 32'd0);
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_occ", 32'(occupancy), 32'd0);
    check_val("rst_done", 32'(all_done), 32'd0);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    step();

    // Fill then replay four entries at level 0
    for (int i = 0; i < 4; i++) wr(16'h0010 + 16'(i));
    check_val("fill_occ", 32'(occupancy), 32'd4);
    check_val("fill_novalid", 32'(internal_valid), 32'd0);
    replay_ready = 1'b1;
    pulse_level_done();
    for (int i = 0; i < 4; i++) begin
      check_val("rp_valid", 32'(internal_valid), 32'd1);
      check_val("rp_data", 32'(internal_data), 32'h0010 + 32'(i));
      step();
    end
    check_val("rp_end_valid", 32'(internal_valid), 32'd0);
    check_val("rp_end_level", 32'(level), 32'd1);
    check_val("rp_end_occ", 32'(occupancy), 32'd0);

    // Writes appended during the first replay, then replayed at the next level
    pulse_start();
    check_val("start_level", 32'(level), 32'd0);
    for (int i = 0; i < 4; i++) wr(16'h0020 + 16'(i));
    pulse_level_done();
    for (int i = 0; i < 4; i++) begin
      check_val("cw_valid", 32'(internal_valid), 32'd1);
      check_val("cw_data", 32'(internal_data), 32'h0020 + 32'(i));
      if (i < 2) begin
        coarse_coeff_wr_en = 1'b1;
        coarse_in = 16'h00A0 + 16'(i);
      end else begin
        coarse_coeff_wr_en = 1'b0;
      end
      step();
    end
    check_val("cw_end_valid", 32'(internal_valid), 32'd0);
    check_val("cw_end_occ", 32'(occupancy), 32'd2);
    check_val("cw_end_level", 32'(level), 32'd1);
    pulse_level_done();
    for (int i = 0; i < 2; i++) begin
      check_val("cw2_valid", 32'(internal_valid), 32'd1);
      check_val("cw2_data", 32'(internal_data), 32'h00A0 + 32'(i));
      step();
    end
    check_val("cw2_end_valid", 32'(internal_valid), 32'd0);
    check_val("cw2_level", 32'(level), 32'd2);
    check_val("cw2_occ", 32'(occupancy), 32'd0);

    // Termination at the last level with a single entry
    wr(16'h0055);
    check_val("term_occ", 32'(occupancy), 32'd1);
    pulse_level_done();
    check_val("term_done", 32'(all_done), 32'd1);
    check_val("term_valid", 32'(internal_valid), 32'd0);
    wr(16'h0066);
    check_val("term_wr_ign", 32'(occupancy), 32'd1);
    check_val("term_ovf", 32'(overflow), 32'd0);
    check_val("term_data", 32'(internal_data), 32'h0055);
    pulse_level_done();
    check_val("term_hold_done", 32'(all_done), 32'd1);
    check_val("term_hold_valid", 32'(internal_valid), 32'd0);
    check_val("term_hold_level", 32'(level), 32'd2);

    // Overflow and pointer wrap
    pulse_start();
    check_val("ov_start_done", 32'(all_done), 32'd0);
    for (int i = 0; i < 9; i++) wr(16'h0030 + 16'(i));
    check_val("ov_occ", 32'(occupancy), 32'd8);
    check_val("ov_flag", 32'(overflow), 32'd1);
    pulse_level_done();
    check_val("ov_first", 32'(internal_data), 32'h0030);
    coarse_coeff_wr_en = 1'b1;
    coarse_in = 16'h0040;
    step();
    coarse_coeff_wr_en = 1'b0;
    check_val("ov_wp_occ", 32'(occupancy), 32'd8);
    check_val("ov_sticky", 32'(overflow), 32'd1);
    for (int i = 1; i < 8; i++) begin
      check_val("ov_rp_valid", 32'(internal_valid), 32'd1);
      check_val("ov_rp_data", 32'(internal_data), 32'h0030 + 32'(i));
      step();
    end
    check_val("ov_rp_end", 32'(internal_valid), 32'd0);
    check_val("ov_rp_occ", 32'(occupancy), 32'd1);
    pulse_level_done();
    check_val("ov_done", 32'(all_done), 32'd1);
    check_val("ov_wrap_data", 32'(internal_data), 32'h0040);

    // Backpressure
    pulse_start();
    check_val("bp_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 3; i++) wr(16'h0070 + 16'(i));
    replay_ready = 1'b0;
    pulse_level_done();
    check_val("bp_d0", 32'(internal_data), 32'h0070);
    replay_ready = 1'b1; step();
    check_val("bp_d1", 32'(internal_data), 32'h0071);
    replay_ready = 1'b0; step();
    check_val("bp_hold1", 32'(internal_data), 32'h0071);
    check_val("bp_hold1_v", 32'(internal_valid), 32'd1);
    replay_ready = 1'b1; step();
    check_val("bp_d2", 32'(internal_data), 32'h0072);
    replay_ready = 1'b0; step();
    check_val("bp_hold2", 32'(internal_data), 32'h0072);
    check_val("bp_occ", 32'(occupancy), 32'd1);
    replay_ready = 1'b1; step();
    check_val("bp_end_valid", 32'(internal_valid), 32'd0);
    check_val("bp_end_level", 32'(level), 32'd1);

    // Asynchronous reset in the middle of a replay
    pulse_start();
    for (int i = 0; i < 3; i++) wr(16'h0080 + 16'(i));
    replay_ready = 1'b0;
    pulse_level_done();
    check_val("ar_valid_pre", 32'(internal_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar_valid", 32'(internal_valid), 32'd0);
    check_val("ar_occ", 32'(occupancy), 32'd0);
    check_val("ar_level", 32'(level), 32'd0);
    check_val("ar_done", 32'(all_done), 32'd0);
    check_val("ar_ovf", 32'(overflow), 32'd0);
    step();
    rst_n = 1'b1;
    replay_ready = 1'b1;
    step();
    step();
    check_val("ar_post_valid", 32'(internal_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/coarse_coeff_buffer.md
COARSE_COEFF_BUFFER -- requirements
Module: coarse_coeff_buffer

Interface
Parameters:
REQ-001 The block SHALL provide these parameters:
- DATA_W, 16, coefficient width.
- DEPTH, 8, buffer entries (power of 2).
- NUM_LEVELS, 3, decomposition levels.

Ports:
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  one-cycle pulse: flush buffer, level:=0, enter FILL.
REQ-005 coarse_coeff_wr_en  in  1  write strobe from lifting controller.
REQ-006 coarse_in  in  DATA_W  coarse coefficient to store.
REQ-007 level_done  in  1  one-cycle pulse: current level's input fully consumed.
REQ-008 replay_ready  in  1  lifting datapath accepts a replayed sample.
REQ-009 internal_valid  out  1  replayed sample valid; feeds lifting controller internal_valid.
REQ-010 internal_data  out  DATA_W  replayed coarse coefficient.
REQ-011 level  out  2  current decomposition level, 0-based.
REQ-012 occupancy  out  $clog2(DEPTH)+1  stored entries.
REQ-013 all_done  out  1  final approximation reached; high while in DONE.
REQ-014 overflow  out  1  sticky: a write was dropped.

Function
REQ-015 Storage SHALL be a circular FIFO of DEPTH x DATA_W with wr_ptr, rd_ptr wrapping DEPTH-1 -> 0.
REQ-016 FSM states SHALL be FILL, REPLAY, DONE.
REQ-017 Write accepted when coarse_coeff_wr_en=1 and (occupancy<DEPTH or pop this cycle), in any state except DONE; mem[wr_ptr]<=coarse_in, wr_ptr++.
REQ-018 Write while full with no simultaneous pop SHALL be dropped and set overflow; overflow cleared only by reset or start.
REQ-019 Pop SHALL occur when internal_valid=1 and replay_ready=1; rd_ptr++, remaining--.
REQ-020 occupancy SHALL update +1 on write only, -1 on pop only, unchanged on both.
REQ-021 internal_data SHALL equal mem[rd_ptr] combinationally; internal_valid SHALL be (state==REPLAY && remaining!=0).
REQ-022 FILL + level_done: if occupancy>=2 and level<NUM_LEVELS-1 -> REPLAY, remaining:=occupancy (including any same-cycle write); else -> DONE.
REQ-023 First internal_valid SHALL be the cycle after the level_done edge (one-cycle latency).
REQ-024 Writes arriving during REPLAY SHALL be appended and SHALL NOT be counted in remaining.
REQ-025 REPLAY with remaining reaching 0 on a pop SHALL go to FILL next edge and increment level.
REQ-026 level_done during REPLAY or DONE SHALL be ignored.
REQ-027 DONE SHALL hold all_done=1, ignore writes and level_done, and keep data readable; exit only via start or reset.
REQ-028 start SHALL override all other inputs in that cycle: pointers, occupancy, remaining, level, overflow := 0, state := FILL.
REQ-029 remaining SHALL be $clog2(DEPTH)+1 bits and never underflow.

Reset
REQ-030 rst_n=0 SHALL immediately force state=FILL, pointers/occupancy/remaining/level=0, internal_valid=0, all_done=0, overflow=0, independent of clk.
REQ-031 Memory contents SHALL need no reset; internal_data is don't-care while internal_valid=0.
REQ-032 Reset asserted mid-REPLAY SHALL abort replay with no further internal_valid until a new level_done.

Verification
REQ-033 Fill/replay: write 0x0010..0x0013 with 4 wr_en pulses, pulse level_done, replay_ready=1 -> internal_valid high 4 consecutive cycles starting cycle after level_done, data 0x0010,0x0011,0x0012,0x0013, then level=1, state FILL, occupancy=0.
REQ-034 Concurrent write: during level-1 replay of 4 entries, write 0x00A0,0x00A1 -> exactly 4 replayed, occupancy=2 after replay, next level_done replays 0x00A0,0x00A1, level=2.
REQ-035 Termination: level=2 with 1 entry, level_done -> all_done=1, internal_valid stays 0; further writes ignored, occupancy unchanged.
REQ-036 Overflow/wrap: 9 writes into empty buffer -> occupancy=8, overflow=1, 9th value absent; write+pop while full at wrap -> occupancy stays 8, wr_ptr wraps to 0.
REQ-037 Backpressure: replay_ready toggling 1,0,1,0 -> internal_data held stable while replay_ready=0, no sample lost or duplicated.
REQ-038 Async reset: assert rst_n=0 mid-edge during REPLAY -> internal_valid drops before next clk edge, all outputs 0.
